// File: rtl/mvb_rx_frame_buffer.sv
// rtl/mvb_rx_frame_buffer.sv - two-bank MVB receive frame buffer with read/ack handshake to the CPU side
// Optional: MVB_RXBUF_ERR_DROP_EN discards errored or length-mismatched frames instead of committing them.
module mvb_rx_frame_buffer #(
    parameter int BANK_WORDS = 16,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk_24M,
    input  logic                  RESET,
    input  logic                  word_valid,
    input  logic [15:0]           word_data,
    input  logic                  frame_over,
    input  logic [6:0]            exp_words,
    input  logic [4:0]            err_flags,
    output logic                  frame_ready,
    output logic [4:0]            frame_words,
    output logic [7:0]            frame_status,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    input  logic                  frame_ack,
    output logic [DROP_CNT_W-1:0] drop_count
);
    localparam int IW = $clog2(BANK_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DISCARD} state_t;

    state_t                state_q, state_d;
    logic [15:0]           mem_q [2][BANK_WORDS];
    logic [1:0]            full_q, full_d;
    logic                  wb_q, rb_q;
    logic [4:0]            wcnt_q, wcnt_d;
    logic                  trunc_q, trunc_d;
    logic [4:0]            words_q [2];
    logic [7:0]            status_q [2];
    logic [4:0]            rptr_q;
    logic [15:0]           rd_data_q;
    logic [DROP_CNT_W-1:0] drop_q;

    logic          store_en;
    logic [IW-1:0] store_idx;
    logic          close_en;
    logic          discard_end;
    logic          len_mis;
    logic          commit_en;
    logic          drop_inc;
    logic          ack_hit;
    logic          rd_hit;

    always_ff @(posedge clk_24M) begin
        if (!RESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (word_valid && !frame_over)
                    state_d = full_q[wb_q] ? S_DISCARD : S_FILL;
            end
            S_FILL:    if (frame_over) state_d = S_IDLE;
            S_DISCARD: if (frame_over) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        store_en    = 1'b0;
        store_idx   = wcnt_q[IW-1:0];
        wcnt_d      = wcnt_q;
        trunc_d     = trunc_q;
        close_en    = 1'b0;
        discard_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (word_valid) begin
                    if (!full_q[wb_q]) begin
                        store_en  = 1'b1;
                        store_idx = '0;
                        wcnt_d    = 5'd1;
                        trunc_d   = 1'b0;
                        close_en  = frame_over;
                    end else begin
                        discard_end = frame_over;
                    end
                end
            end
            S_FILL: begin
                if (word_valid) begin
                    if (wcnt_q < 5'(BANK_WORDS)) begin
                        store_en = 1'b1;
                        wcnt_d   = wcnt_q + 5'd1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                end
                close_en = frame_over;
            end
            S_DISCARD: discard_end = frame_over;
            default: ;
        endcase
    end

    // A truncated frame received more words than any legal expected count.
    assign len_mis = (wcnt_d != exp_words[4:0]) || (exp_words > 7'(BANK_WORDS)) || trunc_d;

`ifdef MVB_RXBUF_ERR_DROP_EN
    assign commit_en = close_en && !(len_mis || (|err_flags));
    assign drop_inc  = discard_end || (close_en && !commit_en);
`else
    assign commit_en = close_en;
    assign drop_inc  = discard_end;
`endif

    assign ack_hit = frame_ack && full_q[rb_q];
    assign rd_hit  = rd_en && full_q[rb_q];

    // Commit and ack never target the same bank: commit needs it FREE, ack needs it FULL.
    always_comb begin
        full_d = full_q;
        if (commit_en) full_d[wb_q] = 1'b1;
        if (ack_hit)   full_d[rb_q] = 1'b0;
    end

    always_ff @(posedge clk_24M) begin
        if (store_en) mem_q[wb_q][store_idx] <= word_data;
    end

    always_ff @(posedge clk_24M) begin
        if (!RESET) begin
            full_q      <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wcnt_q      <= '0;
            trunc_q     <= 1'b0;
            words_q[0]  <= '0;
            words_q[1]  <= '0;
            status_q[0] <= '0;
            status_q[1] <= '0;
            rptr_q      <= '0;
            rd_data_q   <= '0;
            drop_q      <= '0;
        end else begin
            full_q  <= full_d;
            wcnt_q  <= wcnt_d;
            trunc_q <= trunc_d;
            if (commit_en) begin
                words_q[wb_q]  <= wcnt_d;
                status_q[wb_q] <= {wb_q, trunc_d, len_mis, err_flags};
                wb_q           <= ~wb_q;
            end
            if (drop_inc && (drop_q != '1))
                drop_q <= drop_q + 1'b1;
            if (rd_hit) begin
                if (rptr_q < words_q[rb_q]) begin
                    rd_data_q <= mem_q[rb_q][rptr_q[IW-1:0]];
                    rptr_q    <= rptr_q + 5'd1;
                end else begin
                    rd_data_q <= '0;
                end
            end
            if (ack_hit) begin
                rb_q   <= ~rb_q;
                rptr_q <= '0;
            end
        end
    end

    assign frame_ready  = full_q[rb_q];
    assign frame_words  = words_q[rb_q];
    assign frame_status = status_q[rb_q];
    assign rd_data      = rd_data_q;
    assign drop_count   = drop_q;
endmodule
